prng_byte_packer: RTL and testbench
===================================

// Module: prng_byte_packer
// PURPOSE
//  Downstream stage of the 8-bit LFSR PRNG. Accepts one PRNG byte per qualified cycle, packs
//  WORD_BYTES consecutive bytes into a wide word and buffers words in a small FIFO. Drains them
//  over a valid/ready interface to the consumer (test-pattern source / scrambler seed loader).
//  Counts words dropped on FIFO overflow; optionally flags a stuck (locked-up) PRNG stream.
// PARAMETERS
//  WORD_BYTES   4    bytes per output word (>=2)
//  FIFO_DEPTH   4    output FIFO entries, power of 2 (>=2)
//  STUCK_LIMIT  16   consecutive identical accepted bytes that raise stuck (PRNG_STUCK_DET_EN only)
// PORTS
//  clk          in   1               clock, all state on rising edge
//  reset        in   1               asynchronous, active-high; clears all state
//  in_valid     in   1               in_byte qualifier; no backpressure, every valid byte is taken
//  in_byte      in   8               PRNG sample
//  out_valid    out  1               FIFO non-empty
//  out_ready    in   1               consumer accepts out_word when out_valid && out_ready
//  out_word     out  8*WORD_BYTES    FIFO head word; first byte in [7:0]
//  clear_flags  in   1               synchronous clear of drop_cnt, overflow, stuck
//  drop_cnt     out  16              words dropped, saturates at 16'hFFFF
//  overflow     out  1               sticky: at least one word dropped
//  stuck        out  1               sticky stuck-stream flag (0 when feature compiled out)
// BEHAVIOUR
//  - Reset: out_valid=0, out_word=0, drop_cnt=0, overflow=0, stuck=0; byte index=0, partial word
//    discarded, FIFO empty, run counter=0. Reset mid-operation discards everything in flight.
//  - Packing: byte index idx 0..WORD_BYTES-1; in_valid writes in_byte to lane idx, idx++.
//    Idle cycles (in_valid=0) hold idx and the partial word; no timeout.
//  - Word complete when in_valid && idx==WORD_BYTES-1: idx wraps to 0, full word pushed to FIFO
//    at that edge. out_valid rises the next cycle if FIFO was empty (latency 1 cycle after last byte).
//  - FIFO: in-order. Pop on out_valid && out_ready. out_word/out_valid stable while
//    out_valid && !out_ready. Push and pop in the same cycle are both honoured, including when full.
//  - Overflow: word completes, FIFO full, no pop that cycle -> word discarded, drop_cnt+1
//    (saturating), overflow=1. Packing continues with idx=0; FIFO contents untouched.
//  - clear_flags: next cycle drop_cnt=0, overflow=0, stuck=0. Simultaneous with a drop: drop
//    wins -> drop_cnt=1, overflow=1. Simultaneous with stuck detection: stuck=1.
//  - No state machine beyond idx counter, FIFO pointers, flags; all outputs registered except
//    out_word (FIFO head read) and out_valid (from registered count).
// CONFIGURATION
//  PRNG_STUCK_DET_EN defined: previous accepted byte registered; run counter increments when
//    accepted byte equals previous, else resets to 1. Run reaching STUCK_LIMIT sets stuck (sticky
//    until clear_flags/reset). Targets XNOR-LFSR lock-up at 8'hFF. First byte after reset starts run=1.
//  PRNG_STUCK_DET_EN undefined: no comparator/counter logic; stuck tied to 0; port retained.
// STRUCTURE
//  - prng_pkg: localparam PRNG_BYTE_W=8; typedef logic [PRNG_BYTE_W-1:0] prng_byte_t;
//    DROP_CNT_W=16. Shared with the LFSR and future PRNG consumers.
//  - Sub-module prng_sync_fifo (WIDTH, DEPTH): single clock, async active-high reset,
//    push/pop/full/empty, head data out, simultaneous push+pop when full allowed.
//  - Top holds lane register, idx counter, drop/flag logic, optional stuck detector.
// TESTING (WORD_BYTES=4, FIFO_DEPTH=4, STUCK_LIMIT=16)
//  1. out_ready=1, bytes 01,02,03,04 back-to-back -> out_valid=1 for exactly one cycle, one cycle
//     after 04, out_word=32'h04030201.
//  2. out_ready=0, 20 bytes 00..13 -> 4 words held, drop_cnt=1, overflow=1; then out_ready=1 ->
//     32'h03020100, 07060504, 0B0A0908, 0F0E0D0C in order; 13121110 never appears.
//  3. FIFO full, out_ready=1 in the cycle the 5th word's last byte arrives -> no drop,
//     drop_cnt=0, FIFO stays 4 deep with new word at tail.
//  4. Bytes AA,BB then reset pulse, then 01..04 -> out_valid=0 through reset,
//     next word 32'h04030201 (AA/BB gone); drop_cnt=0.
//  5. in_valid toggled 1/0 with bytes 11,22,33,44 -> out_word=32'h44332211; clear_flags with a
//     coincident drop -> drop_cnt=1, overflow=1.
//  6. PRNG_STUCK_DET_EN: 16 accepted 8'hFF -> stuck=1 after 16th; 15 then 8'hFE -> stuck=0;
//     clear_flags -> 0. Macro undefined: same stimulus, stuck stays 0.

Source files
------------

// File: rtl/prng_pkg.sv
// rtl/prng_pkg.sv - shared PRNG widths and byte type
package prng_pkg;
   localparam int PRNG_BYTE_W = 8;
   localparam int DROP_CNT_W  = 16;
   typedef logic [PRNG_BYTE_W-1:0] prng_byte_t;
endpackage

// File: rtl/prng_sync_fifo.sv
// rtl/prng_sync_fifo.sv - single-clock FIFO with head read; push+pop allowed when full
module prng_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign pop_data  = r_mem[r_rd_ptr];

   // memory is cleared too so the head reads zero out of reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
      end
   end
endmodule

// File: rtl/prng_byte_packer.sv
// rtl/prng_byte_packer.sv - packs PRNG bytes into words, buffers and drains them
// Optional stuck-stream detector enabled by defining PRNG_STUCK_DET_EN.
module prng_byte_packer
   import prng_pkg::*;
#(
   parameter int WORD_BYTES  = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int STUCK_LIMIT = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   input  prng_byte_t                        in_byte,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [PRNG_BYTE_W*WORD_BYTES-1:0] out_word,
   input  logic                              clear_flags,
   output logic [DROP_CNT_W-1:0]             drop_cnt,
   output logic                              overflow,
   output logic                              stuck
);
   localparam int IDX_W  = $clog2(WORD_BYTES);
   localparam int WORD_W = PRNG_BYTE_W * WORD_BYTES;

   if (WORD_BYTES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
       || STUCK_LIMIT < 1) begin : g_bad_params
      $error("prng_byte_packer: illegal parameter set");
   end

   logic [IDX_W-1:0]              r_idx;
   logic [WORD_W-PRNG_BYTE_W-1:0] r_lanes;
   logic [DROP_CNT_W-1:0]         r_drop_cnt;
   logic                          r_overflow;
   logic                          w_last;
   logic                          w_pop;
   logic                          w_full;
   logic                          w_empty;
   logic                          w_drop;
   logic [WORD_W-1:0]             w_word;

   assign w_last    = in_valid && (r_idx == IDX_W'(WORD_BYTES - 1));
   assign w_pop     = !w_empty && out_ready;
   assign w_drop    = w_last && w_full && !w_pop;
   // the last byte goes straight into the top lane of the pushed word
   assign w_word    = {in_byte, r_lanes};
   assign out_valid = !w_empty;
   assign drop_cnt  = r_drop_cnt;
   assign overflow  = r_overflow;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx   <= '0;
         r_lanes <= '0;
      end else if (in_valid) begin
         r_idx <= w_last ? '0 : r_idx + 1'b1;
         for (int i = 0; i < WORD_BYTES - 1; i++)
            if (r_idx == IDX_W'(i)) r_lanes[i*PRNG_BYTE_W +: PRNG_BYTE_W] <= in_byte;
      end
   end

   // a drop outranks a coincident clear, so the new drop is still counted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_drop_cnt <= '0;
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (clear_flags)       r_drop_cnt <= DROP_CNT_W'(1);
         else if (~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + 1'b1;
      end else if (clear_flags) begin
         r_drop_cnt <= '0;
         r_overflow <= 1'b0;
      end
   end

   prng_sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (w_last),
      .push_data (w_word),
      .pop       (w_pop),
      .pop_data  (out_word),
      .full      (w_full),
      .empty     (w_empty)
   );

`ifdef PRNG_STUCK_DET_EN
   localparam int RUN_W = $clog2(STUCK_LIMIT + 1);

   prng_byte_t       r_prev;
   logic             r_prev_vld;
   logic [RUN_W-1:0] r_run;
   logic             r_stuck;
   logic [RUN_W-1:0] w_run_next;
   logic             w_stuck_hit;

   // run saturates at the limit so a locked stream keeps re-asserting after a clear
   always_comb begin
      w_run_next = RUN_W'(1);
      if (r_prev_vld && in_byte == r_prev)
         w_run_next = (r_run == RUN_W'(STUCK_LIMIT)) ? r_run : r_run + 1'b1;
      w_stuck_hit = in_valid && (w_run_next == RUN_W'(STUCK_LIMIT));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev     <= '0;
         r_prev_vld <= 1'b0;
         r_run      <= '0;
         r_stuck    <= 1'b0;
      end else begin
         if (in_valid) begin
            r_prev     <= in_byte;
            r_prev_vld <= 1'b1;
            r_run      <= w_run_next;
         end
         if (w_stuck_hit)      r_stuck <= 1'b1;
         else if (clear_flags) r_stuck <= 1'b0;
      end
   end

   assign stuck = r_stuck;
`else
   assign stuck = 1'b0;
`endif
endmodule

// File: tb/tb_prng_byte_packer.sv
// tb/tb_prng_byte_packer.sv - scoreboard bench for prng_byte_packer (4 bytes/word, depth 4)
module tb_prng_byte_packer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_byte = 8'h00;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_word;
   logic        clear_flags = 1'b0;
   logic [15:0] drop_cnt;
   logic        overflow;
   logic        stuck;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   prng_byte_packer #(.WORD_BYTES(4), .FIFO_DEPTH(4), .STUCK_LIMIT(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_byte     (in_byte),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_word    (out_word),
      .clear_flags (clear_flags),
      .drop_cnt    (drop_cnt),
      .overflow    (overflow),
      .stuck       (stuck)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every accepted word must match the scoreboard head
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %h expected none", out_word);
         end else begin
            logic [31:0] exp_w;
            exp_w = sb.pop_front();
            if (out_word !== exp_w) begin
               errors++;
               $display("FAIL word_order: got %h expected %h", out_word, exp_w);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_byte  = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_run(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) send(first + 8'(i));
   endtask

   task automatic drain(input string name);
      int n;
      out_ready = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      tick();
      check(name, 32'(sb.size()), 32'd0);
      check({name, "_idle"}, 32'(out_valid), 32'd0);
   endtask

   task automatic pulse_clear();
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
   endtask

   initial begin
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_word", out_word, 32'd0);
      check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      check("reset_stuck", 32'(stuck), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // 1: single word, out_valid one cycle after the last byte, for one cycle
      out_ready = 1'b1;
      sb.push_back(32'h04030201);
      send(8'h01); send(8'h02); send(8'h03);
      check("t1_not_early", 32'(out_valid), 32'd0);
      send(8'h04);
      check("t1_valid_rise", 32'(out_valid), 32'd1);
      tick();
      check("t1_valid_fall", 32'(out_valid), 32'd0);

      // 2: overflow with consumer stalled
      out_ready = 1'b0;
      sb.push_back(32'h03020100); sb.push_back(32'h07060504);
      sb.push_back(32'h0B0A0908); sb.push_back(32'h0F0E0D0C);
      send_run(8'h00, 20);
      check("t2_drop_cnt", 32'(drop_cnt), 32'd1);
      check("t2_overflow", 32'(overflow), 32'd1);
      check("t2_held_head", out_word, 32'h03020100);
      drain("t2_drain");
      pulse_clear();
      check("t2_clr_drop", 32'(drop_cnt), 32'd0);
      check("t2_clr_ovf", 32'(overflow), 32'd0);

      // 3: full FIFO with a pop on the completing edge does not drop
      out_ready = 1'b0;
      sb.push_back(32'h23222120); sb.push_back(32'h27262524);
      sb.push_back(32'h2B2A2928); sb.push_back(32'h2F2E2D2C);
      sb.push_back(32'h33323130);
      send_run(8'h20, 19);
      out_ready = 1'b1;
      send(8'h33);
      out_ready = 1'b0;
      check("t3_drop_cnt", 32'(drop_cnt), 32'd0);
      check("t3_overflow", 32'(overflow), 32'd0);
      check("t3_new_head", out_word, 32'h27262524);
      drain("t3_drain");

      // 4: reset mid-word discards the partial word
      send(8'hAA); send(8'hBB);
      reset = 1'b1;
      #1;
      check("t4_valid_in_reset", 32'(out_valid), 32'd0);
      tick();
      check("t4_valid_held_reset", 32'(out_valid), 32'd0);
      reset = 1'b0;
      tick();
      sb.push_back(32'h04030201);
      send_run(8'h01, 4);
      drain("t4_drain");
      check("t4_drop_cnt", 32'(drop_cnt), 32'd0);

      // 5: gapped input, then clear coinciding with a drop
      out_ready = 1'b1;
      sb.push_back(32'h44332211);
      send(8'h11); tick(); send(8'h22); tick(); send(8'h33); tick(); tick(); send(8'h44);
      tick(); tick();
      out_ready = 1'b0;
      sb.push_back(32'h53525150); sb.push_back(32'h57565554);
      sb.push_back(32'h5B5A5958); sb.push_back(32'h5F5E5D5C);
      send_run(8'h50, 24);
      check("t5_drop_two", 32'(drop_cnt), 32'd2);
      send_run(8'h68, 3);
      clear_flags = 1'b1;
      send(8'h6B);
      clear_flags = 1'b0;
      check("t5_clr_drop_cnt", 32'(drop_cnt), 32'd1);
      check("t5_clr_overflow", 32'(overflow), 32'd1);
      drain("t5_drain");
      pulse_clear();
      check("t5_clr_after", 32'(drop_cnt), 32'd0);

      // 6: stuck-stream detection
      out_ready = 1'b1;
      sb.push_back(32'hFFFFFFFF); sb.push_back(32'hFFFFFFFF);
      sb.push_back(32'hFFFFFFFF); sb.push_back(32'hFEFFFFFF);
      for (int i = 0; i < 15; i++) send(8'hFF);
      send(8'hFE);
      check("t6_run_broken", 32'(stuck), 32'd0);
      for (int i = 0; i < 4; i++) sb.push_back(32'hFFFFFFFF);
      for (int i = 0; i < 15; i++) send(8'hFF);
      check("t6_before_limit", 32'(stuck), 32'd0);
      send(8'hFF);
`ifdef PRNG_STUCK_DET_EN
      check("t6_stuck_set", 32'(stuck), 32'd1);
`else
      check("t6_stuck_off", 32'(stuck), 32'd0);
`endif
      tick(); tick();
      pulse_clear();
      check("t6_stuck_clear", 32'(stuck), 32'd0);
      drain("t6_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
